ammo_sat_counter: RTL and testbench
===================================

// Module: ammo_sat_counter
// PURPOSE
//   Saturating ammunition counter for the weapons subsystem, built from register (DFF) and mux (Mux2/Mux4) stages.
//   Holds a programmable maximum capacity and the current ammo count.
//   Supports reload (load), per-cycle refill (up) and rate-sized decrement on fire.
//   Gates firing by weapon mode and reload state, and flags illegal fire attempts.
// PARAMETERS
//   N          9            width of ammo count, capacity and fire rate
//   MAX_RESET  (1<<N)-1     capacity value loaded into the max register on reset
// PORTS
//   clk        in   1   rising-edge clock, single clock domain
//   rst        in   1   asynchronous active-high reset
//   load       in   1   reload: count <= in (clamped to max)
//   load_max   in   1   capacity load: max <= in
//   up         in   1   refill count by 1 toward max
//   fire       in   1   fire request
//   mode_sel   in   2   weapon mode; 2'b10 = attack mode, all other codes are non-attack
//   in         in   N   reload / capacity value
//   rate       in   N   rounds consumed per accepted shot
//   ammo       out  N   current count (registered)
//   max_ammo   out  N   current capacity (registered)
//   empty      out  1   ammo == 0 (combinational from ammo)
//   full       out  1   ammo == max_ammo (combinational)
//   error      out  1   registered illegal-fire flag
// BEHAVIOUR
//   Reset (async, any time, including mid-operation):
//     - ammo = 0, max_ammo = MAX_RESET, error = 0
//     - hence empty = 1, full = 0
//   All state updates occur on the rising clk edge while rst is low.
//   Max register:
//     - load_max = 1: max_ammo <= in
//     - otherwise max_ammo holds
//   shoot = fire & ~load & (mode_sel == 2'b10)
//     - fire is ignored while reloading or outside attack mode
//   Count next-state priority (4-way mux): rst > load > shoot > up > hold
//     - load:  ammo <= (in > max_ammo) ? max_ammo : in
//       Compares against the pre-edge max_ammo, even if load_max is asserted in the same cycle.
//     - shoot: ammo <= (ammo > rate) ? ammo - rate : 0
//       Saturates at 0 with no wrap; rate = 0 leaves ammo unchanged.
//     - up:    ammo <= (ammo < max_ammo) ? ammo + 1 : max_ammo
//       Also clamps ammo down to max_ammo if the capacity was lowered below the count.
//     - shoot and up in the same cycle: shoot wins, up is ignored.
//     - none asserted: hold.
//   Error flag:
//     - error <= fire & ((mode_sel != 2'b10) | (ammo == 0))
//     - Registered: one-cycle latency, recomputed every cycle, no sticky state.
//     - Fire during load in attack mode with ammo > 0 is silently ignored, not an error.
//   Arithmetic is unsigned N-bit; no intermediate result may wrap.
// TESTING
//   1. Reset -> ammo=0, max_ammo=511, empty=1, error=0; assert rst mid-count -> immediate clear.
//   2. load_max=1, in=100; next cycle load=1, in=250 -> max_ammo=100, ammo=100 (clamped).
//   3. ammo=100, mode=10, rate=30, fire x4 -> ammo 70, 40, 10, 0; a 5th fire -> ammo=0, error=1 next cycle.
//   4. mode=01, fire=1, ammo=50 -> ammo stays 50, error=1; fire with load=1 in attack mode -> load wins, no error.
//   5. max=5, ammo=3, up x4 -> 4, 5, 5, 5, full=1; lower max to 2 then up -> ammo=2.
//   6. fire and up together with ammo=10, rate=3 -> ammo=7; rate=0 fire -> ammo holds.

Source files
------------

// File: rtl/ammo_sat_counter.sv
// Saturating ammo counter with programmable capacity, reload, refill and rate-sized fire.
// Latency: ammo, max_ammo and error update one cycle after the inputs; empty and full follow ammo combinationally.
// Backpressure: none; every request is taken on each clock, and a losing request is dropped.
module ammo_sat_counter #(
    parameter int          N         = 9,
    parameter int unsigned MAX_RESET = (1 << N) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         load_max,
    input  logic         up,
    input  logic         fire,
    input  logic [1:0]   mode_sel,
    input  logic [N-1:0] in,
    input  logic [N-1:0] rate,
    output logic [N-1:0] ammo,
    output logic [N-1:0] max_ammo,
    output logic         empty,
    output logic         full,
    output logic         error
);

    typedef enum logic [1:0] {
        SEL_LOAD  = 2'd0,
        SEL_SHOOT = 2'd1,
        SEL_UP    = 2'd2,
        SEL_HOLD  = 2'd3
    } cnt_sel_e;

    localparam logic [N-1:0] MAX_RESET_V = N'(MAX_RESET);

    logic         attack;
    logic         shoot;
    cnt_sel_e     cnt_sel;
    logic [N-1:0] load_val;
    logic [N-1:0] shoot_val;
    logic [N-1:0] up_val;
    logic [N-1:0] ammo_nxt;
    logic [N-1:0] max_nxt;
    logic         error_nxt;

    assign attack = (mode_sel == 2'b10);
    assign shoot  = fire & ~load & attack;

    // Each candidate is clamped on its own, so no subtraction or increment can wrap.
    assign load_val  = (in > max_ammo)   ? max_ammo      : in;
    assign shoot_val = (ammo > rate)     ? ammo - rate   : '0;
    assign up_val    = (ammo < max_ammo) ? ammo + 1'b1   : max_ammo;

    always_comb begin
        cnt_sel = SEL_HOLD;
        if (load)
            cnt_sel = SEL_LOAD;
        else if (shoot)
            cnt_sel = SEL_SHOOT;
        else if (up)
            cnt_sel = SEL_UP;
    end

    always_comb begin
        ammo_nxt = ammo;
        case (cnt_sel)
            SEL_LOAD:  ammo_nxt = load_val;
            SEL_SHOOT: ammo_nxt = shoot_val;
            SEL_UP:    ammo_nxt = up_val;
            default:   ammo_nxt = ammo;
        endcase
    end

    assign max_nxt   = load_max ? in : max_ammo;
    assign error_nxt = fire & (~attack | (ammo == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ammo     <= '0;
            max_ammo <= MAX_RESET_V;
            error    <= 1'b0;
        end else begin
            ammo     <= ammo_nxt;
            max_ammo <= max_nxt;
            error    <= error_nxt;
        end
    end

    assign empty = (ammo == '0);
    assign full  = (ammo == max_ammo);

endmodule

// File: tb/tb_ammo_sat_counter.sv
// Directed bench for ammo_sat_counter with hand-computed expected values.
// Inputs are driven 1ns after the rising edge and outputs are sampled there, once the edge has settled.
module tb_ammo_sat_counter;

    localparam int N = 9;

    logic         clk;
    logic         rst;
    logic         load;
    logic         load_max;
    logic         up;
    logic         fire;
    logic [1:0]   mode_sel;
    logic [N-1:0] in;
    logic [N-1:0] rate;
    logic [N-1:0] ammo;
    logic [N-1:0] max_ammo;
    logic         empty;
    logic         full;
    logic         error;

    int checks = 0;
    int errors = 0;

    ammo_sat_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_max (load_max),
        .up       (up),
        .fire     (fire),
        .mode_sel (mode_sel),
        .in       (in),
        .rate     (rate),
        .ammo     (ammo),
        .max_ammo (max_ammo),
        .empty    (empty),
        .full     (full),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clocked cycle with the given controls held across the edge.
    task automatic cyc(input logic l, input logic lm, input logic u, input logic f,
                       input logic [1:0] m, input int unsigned v, input int unsigned r);
        load     = l;
        load_max = lm;
        up       = u;
        fire     = f;
        mode_sel = m;
        in       = N'(v);
        rate     = N'(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        load_max = 1'b0;
        up       = 1'b0;
        fire     = 1'b0;
        mode_sel = 2'b00;
        in       = '0;
        rate     = '0;
        #2;
        check("rst_ammo",  ammo, 0);
        check("rst_max",   max_ammo, 511);
        check("rst_empty", empty, 1);
        check("rst_full",  full, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        rst = 1'b0;

        // Capacity 100, then a reload of 250 is clamped to it.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 100, 0);
        check("ld_max", max_ammo, 100);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 250, 0);
        check("ld_clamp", ammo, 100);
        check("ld_full", full, 1);

        // Fire at rate 30, with the last shot saturating at zero.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 30);
        check("shot1", ammo, 70);
        check("shot1_err", error, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 30);
        check("shot2", ammo, 40);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 30);
        check("shot3", ammo, 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 30);
        check("shot4_sat", ammo, 0);
        check("shot4_err", error, 0);
        check("shot4_empty", empty, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 30);
        check("shot5", ammo, 0);
        check("shot5_err", error, 1);
        idle();
        check("err_clears", error, 0);

        // Fire outside attack mode, then fire masked by a reload.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 50, 0);
        check("reload50", ammo, 50);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 0, 30);
        check("mode01_ammo", ammo, 50);
        check("mode01_err", error, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 60, 30);
        check("fire_ld_ammo", ammo, 60);
        check("fire_ld_err", error, 0);

        // Refill up to a capacity of 5, then lower the capacity under the count.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5, 0);
        check("max5", max_ammo, 5);
        check("max5_notfull", full, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3, 0);
        check("ld3", ammo, 3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        check("up1", ammo, 4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        check("up2", ammo, 5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        check("up3", ammo, 5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        check("up4", ammo, 5);
        check("up4_full", full, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2, 0);
        check("max2_hold", ammo, 5);
        check("max2_notfull", full, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        check("up_clamp", ammo, 2);
        check("up_clamp_full", full, 1);

        // A reload in the same cycle as a capacity load clamps against the old capacity.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 200, 0);
        check("ld_oldmax_ammo", ammo, 2);
        check("ld_oldmax_max", max_ammo, 200);

        // Fire beats up; rate zero holds the count.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 10, 0);
        check("ld10", ammo, 10);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 0, 3);
        check("fire_up", ammo, 7);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 0);
        check("rate0", ammo, 7);
        check("rate0_err", error, 0);

        // Asynchronous reset in mid-operation clears state without a clock edge.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 150, 0);
        check("ld150", ammo, 150);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 0, 0);
        check("pre_rst_err", error, 1);
        fire = 1'b0;
        rst  = 1'b1;
        #1;
        check("arst_ammo",  ammo, 0);
        check("arst_max",   max_ammo, 511);
        check("arst_err",   error, 0);
        check("arst_empty", empty, 1);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        check("post_rst_up", ammo, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
